// File: rtl/weight_buffer_ctrl_if.sv
// weight_buffer_ctrl_if: load/weight/read handshakes plus the SRAM wrapper
// ports of weight_buffer_ctrl; slave is the controller, master its environment.
interface weight_buffer_ctrl_if #(parameter int AW = 11, parameter int LANES = 8);
   logic                  load_start;
   logic [AW-1:0]         load_base;
   logic [13:0]           load_count;
   logic                  w_valid;
   logic [15:0]           w_data;
   logic                  w_ready;
   logic                  load_done;
   logic                  busy;
   logic                  rd_req;
   logic [AW-1:0]         rd_addr;
   logic                  rd_gnt;
   logic                  rd_valid;
   logic [16*LANES-1:0]   rd_data;
   logic [AW-1:0]         sram_A;
   logic [LANES-1:0]      sram_WEAN;
   logic [16*LANES-1:0]   sram_DIA;
   logic                  sram_OEA;
   logic [AW-1:0]         sram_B;
   logic [LANES-1:0]      sram_WEBN;
   logic                  sram_OEB;
   logic [16*LANES-1:0]   sram_DOB;
   modport slave (
      input  load_start, load_base, load_count, w_valid, w_data, rd_req, rd_addr, sram_DOB,
      output w_ready, load_done, busy, rd_gnt, rd_valid, rd_data,
             sram_A, sram_WEAN, sram_DIA, sram_OEA, sram_B, sram_WEBN, sram_OEB
   );
   modport master (
      output load_start, load_base, load_count, w_valid, w_data, rd_req, rd_addr, sram_DOB,
      input  w_ready, load_done, busy, rd_gnt, rd_valid, rd_data,
             sram_A, sram_WEAN, sram_DIA, sram_OEA, sram_B, sram_WEBN, sram_OEB
   );
endinterface

// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl: packs 16-bit weights into SRAM lines via port A and
// serves 1-cycle-latency line reads via port B, stalling reads that hit the line being written.
module weight_buffer_ctrl #(
   parameter int DEPTH = 2016,
   parameter int AW    = 11,
   parameter int LANES = 8
) (
   input logic            clk,
   input logic            rst_n,
   weight_buffer_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
   state_t                    state, state_nx;
   logic [AW-1:0]             line_addr;
   logic [13:0]               remaining;
   logic [$clog2(LANES)-1:0]  lane;
   logic [LANES-1:0]          mask;
   logic [16*LANES-1:0]       pack, rd_hold;
   logic                      rd_valid_q;
   logic                      accept;
   assign accept = state == FILL && bus.w_valid;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.load_start) state_nx = bus.load_count == '0 ? DONE : FILL;
         FILL:    if (accept && (&lane || remaining == 14'd1)) state_nx = WRITE;
         WRITE:   state_nx = remaining == '0 ? DONE : FILL;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         line_addr <= '0;
         remaining <= '0;
         lane      <= '0;
         mask      <= '0;
         pack      <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.load_start) begin
            line_addr <= bus.load_base;
            remaining <= bus.load_count;
            lane      <= '0;
            mask      <= '0;
         end
         if (accept) begin
            pack[16*lane +: 16] <= bus.w_data;
            mask[lane]          <= 1'b1;
            remaining           <= remaining - 14'd1;
            lane                <= lane + 1'b1;
         end
         if (state == WRITE) begin
            lane <= '0;
            mask <= '0;
            if (remaining != '0) line_addr <= line_addr == AW'(DEPTH-1) ? '0 : line_addr + 1'b1;
         end
      end
   // Read data passes straight from the SRAM in the valid cycle, then is held.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_hold    <= '0;
      end else begin
         rd_valid_q <= bus.rd_gnt;
         if (rd_valid_q) rd_hold <= bus.sram_DOB;
      end
   assign bus.w_ready   = state == FILL;
   assign bus.busy      = state != IDLE;
   assign bus.load_done = state == DONE;
   assign bus.rd_gnt    = bus.rd_req && !(state == WRITE && bus.rd_addr == line_addr);
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_valid_q ? bus.sram_DOB : rd_hold;
   assign bus.sram_A    = line_addr;
   assign bus.sram_WEAN = state == WRITE ? ~mask : '1;
   assign bus.sram_DIA  = pack;
   assign bus.sram_OEA  = 1'b0;
   assign bus.sram_B    = bus.rd_addr;
   assign bus.sram_WEBN = '1;
   assign bus.sram_OEB  = bus.rd_gnt;
endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// tb_weight_buffer_ctrl: randomized loads and reads against a line-image model
// of the weight SRAM, plus directed hazard, zero-count, busy-ignore and reset cases.
module tb_weight_buffer_ctrl;
   localparam int DEPTH = 2016;
   typedef struct packed {logic [10:0] a; logic [7:0] wean; logic [127:0] dia;} wr_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int cyc, n_cmp, n_err;
   logic [127:0] sram [DEPTH];
   logic [127:0] ref_mem [DEPTH];
   logic [127:0] dob;
   wr_t wr_log[$];
   logic [10:0] touched[$];
   weight_buffer_ctrl_if bus ();
   weight_buffer_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      for (int l = 0; l < 8; l++)
         if (!bus.sram_WEAN[l]) sram[bus.sram_A][16*l +: 16] <= bus.sram_DIA[16*l +: 16];
      if (bus.sram_OEB) dob <= sram[bus.sram_B];
      if (rst_n && bus.sram_WEAN != 8'hFF) wr_log.push_back({bus.sram_A, bus.sram_WEAN, bus.sram_DIA});
   end
   assign bus.sram_DOB = dob;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic reset_checks();
      check("rst_w_ready", bus.w_ready, 0);
      check("rst_load_done", bus.load_done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_wean", bus.sram_WEAN, 8'hFF);
      check("rst_oeb", bus.sram_OEB, 0);
      check("oea_tied", bus.sram_OEA, 0);
      check("webn_tied", bus.sram_WEBN, 8'hFF);
   endtask
   task automatic rd_check(input logic [10:0] a);
      int g = 0;
      @(negedge clk);
      bus.rd_req = 1'b1;
      bus.rd_addr = a;
      #1;
      while (!bus.rd_gnt && g < 20) begin @(negedge clk); #1; g++; end
      check("rd_gnt", bus.rd_gnt, 1);
      @(negedge clk);
      bus.rd_req = 1'b0;
      check("rd_valid", bus.rd_valid, 1);
      check("rd_data", bus.rd_data, ref_mem[a]);
   endtask
   // One load: base, weight count, gapless w_valid, abort after N weights (-1: never),
   // extra load_start while busy, sequential weights 1..N.
   task automatic do_load(input logic [10:0] base, input int cnt, input bit full,
                          input int abort_at, input bit poke, input bit seq);
      logic [15:0] wts[$];
      logic [7:0] exp_wean;
      int acc = 0, g = 0, t0, lines, n;
      bit fire;
      wr_t e;
      lines = (cnt + 7) / 8;
      for (int i = 0; i < cnt; i++) wts.push_back(seq ? 16'(i + 1) : 16'($urandom));
      touched.delete();
      if (abort_at < 0) begin
         for (int i = 0; i < cnt; i++) ref_mem[(int'(base) + i / 8) % DEPTH][16*(i % 8) +: 16] = wts[i];
         for (int j = 0; j < lines; j++) touched.push_back(11'((int'(base) + j) % DEPTH));
      end
      @(negedge clk);
      bus.load_start = 1'b1;
      bus.load_base = base;
      bus.load_count = 14'(cnt);
      t0 = cyc;
      @(negedge clk);
      bus.load_start = 1'b0;
      while (acc < cnt && acc != abort_at && g < 4000) begin
         bus.load_start = poke && g == 2;
         bus.load_base = 11'($urandom_range(DEPTH - 1));
         bus.load_count = 14'd3;
         bus.w_valid = full || $urandom_range(3) != 0;
         bus.w_data = wts[acc];
         fire = bus.w_valid && bus.w_ready;
         @(negedge clk);
         if (fire) acc++;
         g++;
      end
      bus.load_start = 1'b0;
      bus.w_valid = 1'b0;
      check("accepted", acc, abort_at >= 0 ? abort_at : cnt);
      if (abort_at >= 0) return;
      g = 0;
      while (!bus.load_done && g < 50) begin @(negedge clk); g++; end
      check("load_done", bus.load_done, 1);
      if (full) check("done_latency", cyc - t0, cnt + lines + 1);
      bus.load_start = 1'b1;
      bus.load_count = 14'd5;
      @(negedge clk);
      bus.load_start = 1'b0;
      check("start_in_done_ignored", bus.busy, 0);
      check("wr_count", wr_log.size(), lines);
      for (int j = 0; j < lines && wr_log.size() > 0; j++) begin
         e = wr_log.pop_front();
         n = (j == lines - 1 && cnt % 8 != 0) ? cnt % 8 : 8;
         exp_wean = 8'hFF << n;
         check("wr_addr", e.a, (int'(base) + j) % DEPTH);
         check("wr_wean", e.wean, exp_wean);
         if (n == 8) check("wr_dia", e.dia, ref_mem[(int'(base) + j) % DEPTH]);
      end
      wr_log.delete();
   endtask
   task automatic hazard_reader();
      int g = 0;
      while (bus.sram_WEAN == 8'hFF && g < 200) begin @(negedge clk); g++; end
      check("haz_write_addr", bus.sram_A, 2015);
      bus.rd_req = 1'b1;
      bus.rd_addr = 11'd2015;
      #1;
      check("haz_blocked", bus.rd_gnt, 0);
      @(negedge clk);
      check("haz_granted_next", bus.rd_gnt, 1);
      @(negedge clk);
      bus.rd_req = 1'b0;
      check("haz_rd_valid", bus.rd_valid, 1);
      check("haz_rd_data", bus.rd_data, ref_mem[2015]);
      g = 0;
      while (bus.sram_WEAN == 8'hFF && g < 200) begin @(negedge clk); g++; end
      check("conc_write_addr", bus.sram_A, 0);
      bus.rd_req = 1'b1;
      bus.rd_addr = 11'd7;
      #1;
      check("conc_granted", bus.rd_gnt, 1);
      @(negedge clk);
      bus.rd_req = 1'b0;
      check("conc_rd_valid", bus.rd_valid, 1);
      check("conc_rd_data", bus.rd_data, ref_mem[7]);
   endtask
   initial begin
      bus.load_start = 1'b0;
      bus.load_base = '0;
      bus.load_count = '0;
      bus.w_valid = 1'b0;
      bus.w_data = '0;
      bus.rd_req = 1'b0;
      bus.rd_addr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sram[i] = {$urandom, $urandom, $urandom, $urandom};
         ref_mem[i] = sram[i];
      end
      repeat (3) @(negedge clk);
      reset_checks();
      rst_n = 1'b1;
      do_load(11'd5, 8, 1'b1, -1, 1'b0, 1'b1);
      check("seq_line", ref_mem[5], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      foreach (touched[i]) rd_check(touched[i]);
      do_load(11'd100, 3, 1'b1, -1, 1'b0, 1'b0);
      foreach (touched[i]) rd_check(touched[i]);
      fork
         do_load(11'd2015, 16, 1'b1, -1, 1'b0, 1'b0);
         hazard_reader();
      join
      foreach (touched[i]) rd_check(touched[i]);
      do_load(11'd300, 0, 1'b1, -1, 1'b0, 1'b0);
      do_load(11'd50, 20, 1'b1, -1, 1'b1, 1'b0);
      foreach (touched[i]) rd_check(touched[i]);
      do_load(11'd400, 8, 1'b1, 5, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      reset_checks();
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_no_write", wr_log.size(), 0);
      wr_log.delete();
      do_load(11'd400, 8, 1'b1, -1, 1'b0, 1'b0);
      rd_check(11'd400);
      repeat (16) begin
         do_load(11'($urandom_range(DEPTH - 1)), $urandom_range(40), 1'($urandom_range(1)), -1,
                 1'($urandom_range(1)), 1'b0);
         foreach (touched[i]) rd_check(touched[i]);
         rd_check(11'($urandom_range(DEPTH - 1)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
